// File: rtl/psum_accumulator_if.sv
// Psum input stream and requantized output stream of psum_accumulator.
// slave: accumulator side, master: PE array / consumer side.
interface psum_accumulator_if #(
  parameter int BIT_WIDTH  = 8,
  parameter int NUM_KERNEL = 4
);
  logic [BIT_WIDTH*NUM_KERNEL-1:0] i_psum;
  logic [NUM_KERNEL-1:0]           i_psum_val;
  logic [BIT_WIDTH*NUM_KERNEL-1:0] o_data;
  logic                            o_data_val;
  logic                            i_data_rdy;

  modport master (
    output i_psum, i_psum_val, i_data_rdy,
    input  o_data, o_data_val
  );

  modport slave (
    input  i_psum, i_psum_val, i_data_rdy,
    output o_data, o_data_val
  );
endinterface

// File: rtl/psum_accumulator.sv
// Accumulates per-kernel psums over num_acc beats, requantizes, 2-deep out FIFO.
// Ports: clk, rst (async low), run config, bus (psum in / data out), busy/done, err.
module psum_accumulator #(
  parameter int BIT_WIDTH  = 8,
  parameter int NUM_KERNEL = 4,
  parameter int ACC_WIDTH  = 20,
  parameter int CNT_WIDTH  = 8,
  parameter int REG_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [CNT_WIDTH-1:0] i_num_acc,
  input  logic [CNT_WIDTH-1:0] i_num_out,
  input  logic [4:0]           i_shift,
  psum_accumulator_if.slave    bus,
  output logic                 o_busy,
  output logic                 o_done,
  input  logic                 i_err_clr,
  output logic [REG_WIDTH-1:0] err_status
);
  localparam int DW = BIT_WIDTH * NUM_KERNEL;
  localparam logic [CNT_WIDTH-1:0] ONE = 1;
  localparam logic signed [ACC_WIDTH-1:0] MAXV = (2 ** (BIT_WIDTH - 1)) - 1;
  localparam logic signed [ACC_WIDTH-1:0] MINV = -(2 ** (BIT_WIDTH - 1));

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t state_q, state_d;
  logic [CNT_WIDTH-1:0] num_acc_q, num_acc_d;
  logic [CNT_WIDTH-1:0] num_out_q, num_out_d;
  logic [CNT_WIDTH-1:0] beat_q, beat_d;
  logic [CNT_WIDTH-1:0] out_q, out_d;
  logic [4:0] shift_q, shift_d;
  logic signed [ACC_WIDTH-1:0] acc_q [NUM_KERNEL];
  logic signed [ACC_WIDTH-1:0] acc_d [NUM_KERNEL];
  logic [DW-1:0] d0_q, d0_d, d1_q, d1_d, q_vec;
  logic v0_q, v0_d, v1_q, v1_d;
  logic [4:0] err_q, err_d, err_new;
  logic beat, partial, last, push, pop;
  logic signed [ACC_WIDTH-1:0] total;
  logic signed [BIT_WIDTH-1:0] lane;

  function automatic logic [BIT_WIDTH-1:0] requant(
    input logic signed [ACC_WIDTH-1:0] t,
    input logic [4:0] sh
  );
    logic signed [ACC_WIDTH-1:0] s;
    s = t >>> sh;
    if (s > MAXV) return MAXV[BIT_WIDTH-1:0];
    if (s < MINV) return MINV[BIT_WIDTH-1:0];
    return s[BIT_WIDTH-1:0];
  endfunction

  always_comb begin
    state_d   = state_q;
    num_acc_d = num_acc_q;
    num_out_d = num_out_q;
    shift_d   = shift_q;
    beat_d    = beat_q;
    out_d     = out_q;
    acc_d     = acc_q;
    err_new   = '0;
    push      = 1'b0;
    q_vec     = '0;
    o_done    = 1'b0;
    total     = '0;
    lane      = '0;
    beat      = &bus.i_psum_val;
    partial   = |bus.i_psum_val & ~beat;
    last      = beat_q == num_acc_q - ONE;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          num_acc_d = i_num_acc;
          num_out_d = i_num_out;
          shift_d   = i_shift;
          if (i_num_acc == '0 || i_num_out == '0) begin
            err_new[2] = 1'b1;
          end else begin
            state_d = RUN;
            beat_d  = '0;
            out_d   = '0;
            for (int k = 0; k < NUM_KERNEL; k++) acc_d[k] = '0;
          end
        end
      end
      RUN: begin
        if (i_start) err_new[3] = 1'b1;
        if (partial) begin
          err_new[0] = 1'b1;
        end else if (beat) begin
          for (int k = 0; k < NUM_KERNEL; k++) begin
            lane  = bus.i_psum[k*BIT_WIDTH +: BIT_WIDTH];
            total = acc_q[k] + ACC_WIDTH'(lane);
            if (last) begin
              q_vec[k*BIT_WIDTH +: BIT_WIDTH] = requant(total, shift_q);
              acc_d[k] = '0;
            end else begin
              acc_d[k] = total;
            end
          end
          if (last) begin
            push   = 1'b1;
            beat_d = '0;
            out_d  = out_q + ONE;
            if (out_q + ONE == num_out_q) state_d = FLUSH;
          end else begin
            beat_d = beat_q + ONE;
          end
        end
      end
      FLUSH: begin
        if (i_start) err_new[3] = 1'b1;
        if (beat) err_new[4] = 1'b1;
        if (!v0_q) begin
          o_done  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Shift-register FIFO: slot 0 is the head and drives o_data directly,
    // so an emptied FIFO keeps showing the last popped result.
    pop  = v0_q & bus.i_data_rdy;
    d0_d = d0_q;
    d1_d = d1_q;
    v0_d = v0_q;
    v1_d = v1_q;
    if (pop) begin
      v0_d = v1_q;
      v1_d = 1'b0;
      if (v1_q) d0_d = d1_q;
    end
    if (push) begin
      if (!v0_d) begin
        d0_d = q_vec;
        v0_d = 1'b1;
      end else if (!v1_d) begin
        d1_d = q_vec;
        v1_d = 1'b1;
      end else begin
        err_new[1] = 1'b1;
      end
    end
    err_d = (i_err_clr ? 5'd0 : err_q) | err_new;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      num_acc_q <= '0;
      num_out_q <= '0;
      shift_q   <= '0;
      beat_q    <= '0;
      out_q     <= '0;
      for (int k = 0; k < NUM_KERNEL; k++) acc_q[k] <= '0;
      d0_q      <= '0;
      d1_q      <= '0;
      v0_q      <= 1'b0;
      v1_q      <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      num_acc_q <= num_acc_d;
      num_out_q <= num_out_d;
      shift_q   <= shift_d;
      beat_q    <= beat_d;
      out_q     <= out_d;
      for (int k = 0; k < NUM_KERNEL; k++) acc_q[k] <= acc_d[k];
      d0_q      <= d0_d;
      d1_q      <= d1_d;
      v0_q      <= v0_d;
      v1_q      <= v1_d;
      err_q     <= err_d;
    end
  end

  assign bus.o_data     = d0_q;
  assign bus.o_data_val = v0_q;
  assign o_busy = (state_q == RUN) || (state_q == FLUSH && v0_q);
  assign err_status = {{(REG_WIDTH-5){1'b0}}, err_q};
endmodule
